// File: rtl/mul_lanes_mac.sv
// Purpose: LANES parallel unsigned multipliers feeding a sum-of-products / accumulate stage.
// Latency: two register stages (operand/product stage, sum/accumulate stage); one beat per cycle.
// Backpressure: none; every beat accepted on i_en yields exactly one o_dout_en pulse.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_en                  beat valid; i_mode, i_mul_a, i_mul_b sampled when high
//   i_mode                0 = per-beat sum of products, 1 = accumulate
//   i_clr                 accumulator/overflow clear, sampled every cycle
//   i_mul_a, i_mul_b      packed operands, lane i at [i*W +: W]
//   o_dout                result (OW bits, unsigned)
//   o_dout_en             one-cycle result valid pulse per beat
//   o_ovf                 sticky accumulate overflow flag
module mul_lanes_mac #(
  parameter int W        = 4,
  parameter int LANES    = 2,
  parameter int ACC_BITS = 4,
  parameter int SAT      = 0,
  localparam int OW      = 2*W + $clog2(LANES) + ACC_BITS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic               i_clr,
  input  logic [LANES*W-1:0] i_mul_a,
  input  logic [LANES*W-1:0] i_mul_b,
  output logic [OW-1:0]      o_dout,
  output logic               o_dout_en,
  output logic               o_ovf
);

  // Stage 1 state
  logic [2*W-1:0] r_prod [LANES];
  logic           r_v1;
  logic           r_mode1;
  logic           r_clr1;

  // Stage 2 state
  logic [OW-1:0]  r_dout;
  logic           r_dout_en;
  logic           r_ovf;

  logic [2*W-1:0] w_prod [LANES];
  logic [OW-1:0]  w_sum;
  logic [OW-1:0]  w_prev;
  logic [OW:0]    w_total;
  logic           w_carry;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = (2*W)'(i_mul_a[i*W +: W]) * (2*W)'(i_mul_b[i*W +: W]);
    end
  end

  // Products only load on a valid beat so the multiplier outputs stay
  // quiet between beats; clr travels every cycle so it can clear while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_prod[i] <= '0;
      end
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_clr1  <= 1'b0;
    end else begin
      r_v1   <= i_en;
      r_clr1 <= i_clr;
      if (i_en) begin
        r_mode1 <= i_mode;
        for (int i = 0; i < LANES; i++) begin
          r_prod[i] <= w_prod[i];
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + OW'(r_prod[i]);
    end
  end

  // A beat carrying clr accumulates from zero instead of the held result.
  assign w_prev  = r_clr1 ? '0 : r_dout;
  assign w_total = {1'b0, w_prev} + {1'b0, w_sum};
  assign w_carry = w_total[OW];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_dout_en <= r_v1;
      if (r_v1) begin
        if (!r_mode1) begin
          // Sum of products always fits in OW; only clr touches ovf here.
          r_dout <= w_sum;
          if (r_clr1) begin
            r_ovf <= 1'b0;
          end
        end else begin
          r_ovf  <= (r_ovf & ~r_clr1) | w_carry;
          r_dout <= (w_carry && (SAT != 0)) ? {OW{1'b1}} : w_total[OW-1:0];
        end
      end else if (r_clr1) begin
        r_dout <= '0;
        r_ovf  <= 1'b0;
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_dout_en = r_dout_en;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_mul_lanes_mac.sv
module tb_mul_lanes_mac;

  localparam int W = 4;
  localparam int LANES = 2;
  localparam int ACC_BITS = 4;
  localparam int OW = 13;
  localparam int MAXV = 8191;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, mode, clr;
  logic [7:0]    a, b;
  logic [OW-1:0] dout0, dout1;
  logic          den0, den1, ovf0, ovf1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] d;
    logic          o;
    int            c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m_acc [2];
  bit   m_ovf [2];

  mul_lanes_mac #(.W(W), .LANES(LANES), .ACC_BITS(ACC_BITS), .SAT(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_clr(clr),
    .i_mul_a(a), .i_mul_b(b),
    .o_dout(dout0), .o_dout_en(den0), .o_ovf(ovf0)
  );

  mul_lanes_mac #(.W(W), .LANES(LANES), .ACC_BITS(ACC_BITS), .SAT(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_clr(clr),
    .i_mul_a(a), .i_mul_b(b),
    .o_dout(dout1), .o_dout_en(den1), .o_ovf(ovf1)
  );

  // Scoreboard consumer: every dout_en pops one expectation (value, ovf, cycle).
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (den0) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL wrap_spurious_en cyc=%0d dout=%0d", cyc, dout0);
        end else begin
          e = q0.pop_front();
          if (dout0 !== e.d || ovf0 !== e.o || cyc != e.c) begin
            bad++;
            $display("FAIL wrap_result got dout=%0d ovf=%0b cyc=%0d want dout=%0d ovf=%0b cyc=%0d",
                     dout0, ovf0, cyc, e.d, e.o, e.c);
          end
        end
      end else if (q0.size() != 0 && q0[0].c <= cyc) begin
        total++;
        bad++;
        e = q0.pop_front();
        $display("FAIL wrap_missing_en cyc=%0d want dout=%0d at cyc=%0d", cyc, e.d, e.c);
      end
      if (den1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sat_spurious_en cyc=%0d dout=%0d", cyc, dout1);
        end else begin
          e = q1.pop_front();
          if (dout1 !== e.d || ovf1 !== e.o || cyc != e.c) begin
            bad++;
            $display("FAIL sat_result got dout=%0d ovf=%0b cyc=%0d want dout=%0d ovf=%0b cyc=%0d",
                     dout1, ovf1, cyc, e.d, e.o, e.c);
          end
        end
      end else if (q1.size() != 0 && q1[0].c <= cyc) begin
        total++;
        bad++;
        e = q1.pop_front();
        $display("FAIL sat_missing_en cyc=%0d want dout=%0d at cyc=%0d", cyc, e.d, e.c);
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_ovf[s] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Drive one beat for one cycle and push the reference result for both DUTs.
  task automatic beat(input bit m, input bit c, input int a0, input int b0, input int a1, input int b1);
    int   sum, t;
    exp_t e;
    sum = a0 * b0 + a1 * b1;
    for (int s = 0; s < 2; s++) begin
      if (!m) begin
        m_acc[s] = sum;
        if (c) m_ovf[s] = 1'b0;
      end else begin
        t = (c ? 0 : m_acc[s]) + sum;
        if (c) m_ovf[s] = 1'b0;
        if (t > MAXV) begin
          m_ovf[s] = 1'b1;
          m_acc[s] = (s == 1) ? MAXV : (t % (MAXV + 1));
        end else begin
          m_acc[s] = t;
        end
      end
      e.d = OW'(m_acc[s]);
      e.o = m_ovf[s];
      e.c = cyc + 2;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    en   = 1'b1;
    mode = m;
    clr  = c;
    a    = {a1[3:0], a0[3:0]};
    b    = {b1[3:0], b0[3:0]};
    @(posedge clk); #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    en  = 1'b0;
    clr = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q0.size() != 0 || q1.size() != 0) && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout left=%0d/%0d want 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0; a = '0; b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (dout0 !== '0 || dout1 !== '0 || den0 !== 1'b0 || den1 !== 1'b0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got dout=%0d/%0d en=%0b/%0b ovf=%0b/%0b want all 0",
               dout0, dout1, den0, den1, ovf0, ovf1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    beat(1'b0, 1'b0, 3, 5, 2, 7);
    idle(4);
    total++;
    if (dout0 !== 13'd29 || dout1 !== 13'd29) begin
      bad++;
      $display("FAIL single_hold got %0d/%0d want 29", dout0, dout1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) beat(1'b0, 1'b0, 15, 15, 15, 15);
    idle(3);
    drain();
    total++;
    if (dout0 !== 13'd450 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final got dout=%0d ovf=%0b/%0b want 450 ovf 0", dout0, ovf0, ovf1);
    end
  endtask

  task automatic test_accumulate_overflow();
    beat(1'b1, 1'b1, 15, 15, 15, 15);
    for (int i = 1; i < 19; i++) beat(1'b1, 1'b0, 15, 15, 15, 15);
    idle(3);
    drain();
    total++;
    if (dout0 !== 13'd358 || ovf0 !== 1'b1) begin
      bad++;
      $display("FAIL wrap_overflow got dout=%0d ovf=%0b want 358 ovf 1", dout0, ovf0);
    end
    total++;
    if (dout1 !== 13'd8191 || ovf1 !== 1'b1) begin
      bad++;
      $display("FAIL sat_overflow got dout=%0d ovf=%0b want 8191 ovf 1", dout1, ovf1);
    end
    // Mode-0 beats must leave the sticky flag alone.
    beat(1'b0, 1'b0, 1, 1, 0, 0);
    idle(3);
    drain();
    total++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || dout0 !== 13'd1) begin
      bad++;
      $display("FAIL ovf_sticky got ovf=%0b/%0b dout=%0d want ovf 1/1 dout 1", ovf0, ovf1, dout0);
    end
  endtask

  task automatic test_clr_idle();
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_ovf[s] = 1'b0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (dout0 !== '0 || dout1 !== '0 || ovf0 !== 1'b0 || ovf1 !== 1'b0 || den0 !== 1'b0 || den1 !== 1'b0) begin
      bad++;
      $display("FAIL clr_idle got dout=%0d/%0d ovf=%0b/%0b en=%0b/%0b want 0",
               dout0, dout1, ovf0, ovf1, den0, den1);
    end
    idle(2);
  endtask

  task automatic test_mode_switch();
    beat(1'b1, 1'b1, 15, 15, 15, 15);
    beat(1'b1, 1'b0, 3, 5, 2, 7);
    beat(1'b0, 1'b0, 2, 3, 2, 4);
    beat(1'b1, 1'b0, 3, 5, 2, 7);
    idle(3);
    drain();
    total++;
    if (dout0 !== 13'd43 || dout1 !== 13'd43) begin
      bad++;
      $display("FAIL mode_switch_final got %0d/%0d want 43", dout0, dout1);
    end
  endtask

  task automatic test_clr_with_beat();
    for (int i = 0; i < 19; i++) beat(1'b1, (i == 0), 15, 15, 15, 15);
    beat(1'b1, 1'b1, 1, 2, 3, 4);
    idle(3);
    drain();
    total++;
    if (dout0 !== 13'd14 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL clr_beat got dout=%0d ovf=%0b/%0b want 14 ovf 0", dout0, ovf0, ovf1);
    end
  endtask

  task automatic test_reset_inflight();
    en = 1'b1; mode = 1'b0; clr = 1'b0; a = 8'hff; b = 8'hff;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b0;
    model_reset();
    idle(5);
    total++;
    if (dout0 !== '0 || dout1 !== '0 || ovf0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_inflight got dout=%0d/%0d ovf=%0b want 0", dout0, dout1, ovf0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      beat(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
    end
    idle(3);
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_accumulate_overflow();
    test_clr_idle();
    test_mode_switch();
    test_clr_with_beat();
    test_reset_inflight();
    test_random();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_lanes_mac.md
MUL_LANES_MAC -- requirements
Module: mul_lanes_mac

Interface
REQ-001 SHALL have parameter W, default 4, unsigned operand width per lane.
REQ-002 SHALL have parameter LANES, default 2, number of parallel multiplier lanes (>=1).
REQ-003 SHALL have parameter ACC_BITS, default 4, accumulator guard bits.
REQ-004 SHALL have parameter SAT, default 0: 0 = wrap on accumulate overflow, 1 = saturate.
REQ-005 SHALL derive OW = 2*W + clog2(LANES) + ACC_BITS (13 at defaults).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  beat valid; operands sampled when high.
REQ-009 mode  input  1  0 = sum-of-products per beat, 1 = accumulate; sampled with en.
REQ-010 clr  input  1  accumulator clear; sampled every cycle, pipelined with beat.
REQ-011 mul_a  input  LANES*W  packed operand A; lane i at bits [i*W +: W].
REQ-012 mul_b  input  LANES*W  packed operand B, same packing.
REQ-013 dout  output  OW  result, unsigned.
REQ-014 dout_en  output  1  result valid, one-cycle pulse per beat.
REQ-015 ovf  output  1  sticky accumulate-overflow flag.

Function
REQ-016 Stage 1 SHALL register prod_i = a_i*b_i (2W bits each) plus valid, mode and clr when en=1.
REQ-017 Product registers SHALL hold value when en=0 (operand isolation, no toggling); stage-1 valid SHALL be 0.
REQ-018 Stage 2 SHALL compute sum = Σ prod_i, zero-extended to OW, and register the result.
REQ-019 Latency SHALL be exactly 2 cycles: en high at edge N -> dout_en high after edge N+2.
REQ-020 Throughput SHALL be one beat per cycle; back-to-back beats produce back-to-back dout_en.
REQ-021 Mode 0 beat: dout SHALL = sum.
REQ-022 Mode 1 beat: dout SHALL = dout_prev + sum, where dout_prev = 0 if the beat carries clr=1.
REQ-023 Mode switches between consecutive beats SHALL take effect per beat with no bubble; a mode-0 beat overwrites the accumulator.
REQ-024 clr with en=0 SHALL set dout to 0 two cycles later with dout_en=0, and clear ovf.
REQ-025 clr with en=1 SHALL clear ovf and start accumulation from the beat's sum.
REQ-026 Stage-2 cycles with no valid beat and no clr SHALL hold dout; dout_en SHALL be 0.
REQ-027 Mode-1 overflow (dout_prev + sum > 2^OW-1) SHALL set ovf; SAT=0 stores (dout_prev+sum) mod 2^OW, SAT=1 stores 2^OW-1.
REQ-028 ovf SHALL remain set until clr reaches stage 2 or rst.
REQ-029 Mode-0 results SHALL never overflow (guaranteed by OW) and SHALL not affect ovf.

Reset
REQ-030 rst=1 at a rising edge SHALL set dout=0, dout_en=0, ovf=0 and all pipeline registers to 0.
REQ-031 Beats in flight when rst asserts SHALL be discarded; no dout_en from them after reset.
REQ-032 en asserted in the same cycle as rst SHALL be ignored.

Verification (W=4, LANES=2, ACC_BITS=4)
REQ-033 mode 0, a0=3,b0=5,a1=2,b1=7, en one cycle -> dout=29, dout_en one pulse 2 cycles later.
REQ-034 mode 0, all operands 15, 12 back-to-back beats -> 12 consecutive dout_en, dout=450 each, ovf=0.
REQ-035 mode 1, first beat clr=1, 4 beats all operands 15 -> dout 450, 900, 1350, 1800.
REQ-036 mode 1 continuing 450 per beat, 19th beat -> SAT=0: dout=358, ovf=1; SAT=1: dout=8191, ovf=1; then clr with en=0 -> dout=0, ovf=0, no dout_en.
REQ-037 Beats on cycles N and N+1, rst at N+1 -> no dout_en afterward, dout=0.
REQ-038 mode 1 beat (sum 29) then mode 0 beat (sum 14) then mode 1 beat (sum 29) -> dout 29+prev, 14, 43.
